serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 109 ++++++++++
 tb/tb_serial_adder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder: one full-adder cell plus a carry FF, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub port (A - B via inverted B and carry-in of 1).
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             C
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, res_q, s_q;
   logic [CW-1:0]    cnt_q;
   logic             c_q, c_out_q, busy_q, done_q;

   logic [WIDTH-1:0] b_load, res_d;
   logic             c_init;
   logic             hs1, hc1, hc2, sum_bit, carry_d, last_bit;

`ifdef SERIAL_ADDER_SUB_EN
   // Subtract is A + ~B + 1; inverting at load time keeps the cell itself add-only.
   assign b_load = sub ? ~B : B;
   assign c_init = sub;
`else
   assign b_load = B;
   assign c_init = 1'b0;
`endif

   // Full adder as two half adders plus an OR.
   assign hs1     = a_q[0] ^ b_q[0];
   assign hc1     = a_q[0] & b_q[0];
   assign sum_bit = hs1 ^ c_q;
   assign hc2     = hs1 & c_q;
   assign carry_d = hc1 | hc2;

   assign res_d    = {sum_bit, res_q[WIDTH-1:1]};
   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         c_out_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  a_q     <= A;
                  b_q     <= b_load;
                  c_q     <= c_init;
                  cnt_q   <= '0;
                  res_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end else begin
                  state_q <= IDLE;
               end
            end
            SHIFT: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               c_q   <= carry_d;
               res_q <= res_d;
               if (last_bit) begin
                  cnt_q   <= '0;
                  s_q     <= res_d;
                  c_out_q <= carry_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign S    = s_q;
   assign C    = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed-vector bench for serial_adder (WIDTH=8).
// Define SERIAL_ADDER_SUB_EN to also exercise subtraction.
module tb_serial_adder;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] A, B;
   logic       sub_r;
   logic       busy, done, C;
   logic [7:0] S;

   int n_vec = 0;
   int n_err = 0;

   serial_adder #(.WIDTH(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .A    (A),
      .B    (B),
`ifdef SERIAL_ADDER_SUB_EN
      .sub  (sub_r),
`endif
      .busy (busy),
      .done (done),
      .S    (S),
      .C    (C)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // poke_at != 0 re-pulses start with different operands while busy.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp,
                         input string tag, input int poke_at);
      int lat;
      int busy_cnt;
      int extra;
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         if (poke_at != 0 && lat == poke_at) begin
            A = ~a; B = ~b; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check({tag, " latency"}, lat - 1, 8);
      check({tag, " busy_cycles"}, busy_cnt, 8);
      check({tag, " busy_at_done"}, {31'd0, busy}, 0);
      check({tag, " S"}, {24'd0, S}, {24'd0, exp[7:0]});
      check({tag, " C"}, {31'd0, C}, {31'd0, exp[8]});
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) extra++;
      end
      check({tag, " extra_done"}, extra, 0);
      check({tag, " S_held"}, {24'd0, S}, {24'd0, exp[7:0]});
   endtask

   initial begin
      int pulses;
      int last_n;
      rst_n = 1'b0; start = 1'b0; A = '0; B = '0; sub_r = 1'b0;
      #3;
      check("rst busy", {31'd0, busy}, 0);
      check("rst done", {31'd0, done}, 0);
      check("rst S", {24'd0, S}, 0);
      check("rst C", {31'd0, C}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(8'd3,   8'd5,   9'h008, "add_3_5",   0);
      run_op(8'hFF,  8'h01,  9'h100, "add_ff_01", 0);
      run_op(8'd200, 8'd100, 9'h12C, "add_200_100", 0);
      run_op(8'hAA,  8'h55,  9'h0FF, "add_aa_55", 0);
      run_op(8'hFF,  8'hFF,  9'h1FE, "add_ff_ff", 0);
      run_op(8'h10,  8'h22,  9'h032, "ignore_start", 3);

      // start held high: a new operation every 9 cycles
      @(negedge clk);
      A = 8'd1; B = 8'd1; start = 1'b1;
      pulses = 0;
      last_n = -1;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            check("b2b S", {24'd0, S}, 2);
            check("b2b C", {31'd0, C}, 0);
            if (last_n >= 0) check("b2b period", n - last_n, 9);
            else check("b2b first", n, 9);
            last_n = n;
         end
      end
      start = 1'b0;
      check("b2b pulses", pulses, 3);
      repeat (12) @(negedge clk);

      // abort mid-operation with asynchronous reset
      run_op(8'h01, 8'h01, 9'h002, "pre_reset", 0);
      @(negedge clk);
      A = 8'h0F; B = 8'h01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort busy", {31'd0, busy}, 0);
      check("abort done", {31'd0, done}, 0);
      check("abort S", {24'd0, S}, 0);
      check("abort C", {31'd0, C}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("abort no_done", pulses, 0);
      check("abort S_held", {24'd0, S}, 0);
      run_op(8'h7F, 8'h81, 9'h100, "post_reset", 0);

`ifdef SERIAL_ADDER_SUB_EN
      sub_r = 1'b1;
      run_op(8'd5, 8'd3, 9'h102, "sub_5_3", 0);
      run_op(8'd3, 8'd5, 9'h0FE, "sub_3_5", 0);
      sub_r = 1'b0;
      run_op(8'd3, 8'd5, 9'h008, "sub0_3_5", 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
